cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller.sv | 164 ++++++++++++++++
 tb/tb_cpu_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Instruction-decode and sequencing controller for a simple datapath.
// Moore FSM: every datapath control is decoded from the current state and the instruction register.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] ir_r;

  logic [2:0] opcode_s;
  logic [1:0] op_s;
  logic [2:0] rn_s;
  logic [2:0] rd_s;
  logic [2:0] rm_s;
  logic       is_mov_imm_s;
  logic       is_mov_reg_s;
  logic       is_alu_s;
  logic       is_mvn_s;
  logic       is_cmp_s;

  assign opcode_s = ir_r[15:13];
  assign op_s     = ir_r[12:11];
  assign rn_s     = ir_r[10:8];
  assign rd_s     = ir_r[7:5];
  assign rm_s     = ir_r[2:0];

  // Every 101 encoding is an ALU instruction; only two of the 110 encodings are moves.
  assign is_mov_imm_s = (opcode_s == 3'b110) && (op_s == 2'b10);
  assign is_mov_reg_s = (opcode_s == 3'b110) && (op_s == 2'b00);
  assign is_alu_s     = (opcode_s == 3'b101);
  assign is_mvn_s     = is_alu_s && (op_s == 2'b11);
  assign is_cmp_s     = is_alu_s && (op_s == 2'b01);

  assign sximm5 = {{11{ir_r[4]}}, ir_r[4:0]};
  assign sximm8 = {{8{ir_r[7]}}, ir_r[7:0]};

  // State register and instruction capture; reset overrides any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_WAIT;
      ir_r    <= 16'h0000;
    end else begin
      state_r <= next_state_s;
      if ((state_r == S_WAIT) && s) begin
        ir_r <= in;
      end else begin
        ir_r <= ir_r;
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    next_state_s = S_WAIT;
    w            = 1'b0;
    readnum      = 3'b000;
    writenum     = 3'b000;
    vsel         = 4'b0001;
    loada        = 1'b0;
    loadb        = 1'b0;
    asel         = 1'b0;
    bsel         = 1'b0;
    loadc        = 1'b0;
    loads        = 1'b0;
    write        = 1'b0;
    shift        = 2'b00;
    ALUop        = 2'b00;

    case (state_r)
      S_WAIT: begin
        w = 1'b1;
        if (s) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_DECODE: begin
        if (is_mov_imm_s) begin
          next_state_s = S_WRITE_IMM;
        end else if (is_alu_s && !is_mvn_s) begin
          next_state_s = S_GET_A;
        end else if (is_mov_reg_s || is_mvn_s) begin
          next_state_s = S_GET_B;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_GET_A: begin
        readnum      = rn_s;
        loada        = 1'b1;
        next_state_s = S_GET_B;
      end
      S_GET_B: begin
        readnum      = rm_s;
        loadb        = 1'b1;
        next_state_s = S_ALU;
      end
      S_ALU: begin
        shift = ir_r[4:3];
        bsel  = 1'b0;
        asel  = is_mov_reg_s || is_mvn_s;
        if (is_alu_s) begin
          ALUop = op_s;
        end else begin
          ALUop = 2'b00;
        end
        // Compare only updates status; everything else latches C and writes back.
        if (is_cmp_s) begin
          loads        = 1'b1;
          next_state_s = S_WAIT;
        end else begin
          loadc        = 1'b1;
          next_state_s = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum     = rd_s;
        vsel         = 4'b0001;
        write        = 1'b1;
        next_state_s = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum     = rn_s;
        vsel         = 4'b0100;
        write        = 1'b1;
        next_state_s = S_WAIT;
      end
      default: begin
        next_state_s = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: steps through each instruction class state by state.
// Inputs change and outputs are sampled on the falling edge, half a cycle away from the active edge.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic        write;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;

  int total_checks;
  int failed_checks;

  cpu_controller dut (
    .clk(clk), .reset(reset), .in(in), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .write(write),
    .shift(shift), .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector order: {loada, loadb, loadc, loads, write, asel, bsel}
  task automatic ctl(input string tag, input logic e_w, input logic [2:0] e_rn,
                     input logic [2:0] e_wn, input logic [3:0] e_vsel,
                     input logic [6:0] e_strb, input logic [1:0] e_sh,
                     input logic [1:0] e_op);
    logic [21:0] obs;
    logic [21:0] exp;
    obs = {w, readnum, writenum, vsel, loada, loadb, loadc, loads, write, asel, bsel, shift, ALUop};
    exp = {e_w, e_rn, e_wn, e_vsel, e_strb, e_sh, e_op};
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      failed_checks++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input string tag);
    ctl(tag, 1'b1, 3'b000, 3'b000, 4'b0001, 7'b0000000, 2'b00, 2'b00);
  endtask

  task automatic busy_quiet(input string tag);
    ctl(tag, 1'b0, 3'b000, 3'b000, 4'b0001, 7'b0000000, 2'b00, 2'b00);
  endtask

  // Present an instruction with a one-cycle start pulse; returns in DECODE (one edge after capture).
  task automatic start(input logic [15:0] ins);
    in = ins;
    s  = 1'b1;
    @(negedge clk);
    s  = 1'b0;
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    reset = 1'b1;
    s     = 1'b1;
    in    = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    s     = 1'b0;
    idle("reset_outputs");
    chk16("reset_sximm5", sximm5, 16'h0000);
    chk16("reset_sximm8", sximm8, 16'h0000);

    // MOV R1,#7
    start(16'hD107);
    busy_quiet("movi_decode");
    @(negedge clk);
    ctl("movi_write_imm", 1'b0, 3'b000, 3'b001, 4'b0100, 7'b0000100, 2'b00, 2'b00);
    chk16("movi_sximm8", sximm8, 16'h0007);
    @(negedge clk);
    idle("movi_done_3_edges");

    // MOV R1,#-5
    start(16'hD1FB);
    @(negedge clk);
    chk16("movi_neg_sximm8", sximm8, 16'hFFFB);
    chk16("movi_neg_sximm5", sximm5, 16'hFFFB);
    @(negedge clk);
    idle("movi_neg_done");

    // ADD R5,R2,R3
    start(16'hA2A3);
    busy_quiet("add_decode");
    @(negedge clk);
    ctl("add_get_a", 1'b0, 3'b010, 3'b000, 4'b0001, 7'b1000000, 2'b00, 2'b00);
    @(negedge clk);
    ctl("add_get_b", 1'b0, 3'b011, 3'b000, 4'b0001, 7'b0100000, 2'b00, 2'b00);
    @(negedge clk);
    ctl("add_alu", 1'b0, 3'b000, 3'b000, 4'b0001, 7'b0010000, 2'b00, 2'b00);
    @(negedge clk);
    ctl("add_write_reg", 1'b0, 3'b000, 3'b101, 4'b0001, 7'b0000100, 2'b00, 2'b00);
    @(negedge clk);
    idle("add_done");

    // CMP R2,R3
    start(16'hAA03);
    @(negedge clk);
    ctl("cmp_get_a", 1'b0, 3'b010, 3'b000, 4'b0001, 7'b1000000, 2'b00, 2'b00);
    @(negedge clk);
    ctl("cmp_get_b", 1'b0, 3'b011, 3'b000, 4'b0001, 7'b0100000, 2'b00, 2'b00);
    @(negedge clk);
    ctl("cmp_alu", 1'b0, 3'b000, 3'b000, 4'b0001, 7'b0001000, 2'b00, 2'b01);
    @(negedge clk);
    idle("cmp_done_no_write");

    // MOV R7,R1,LSL
    start(16'hC0E9);
    @(negedge clk);
    ctl("movr_get_b", 1'b0, 3'b001, 3'b000, 4'b0001, 7'b0100000, 2'b00, 2'b00);
    @(negedge clk);
    ctl("movr_alu", 1'b0, 3'b000, 3'b000, 4'b0001, 7'b0010010, 2'b01, 2'b00);
    @(negedge clk);
    ctl("movr_write_reg", 1'b0, 3'b000, 3'b111, 4'b0001, 7'b0000100, 2'b00, 2'b00);
    @(negedge clk);
    idle("movr_done");

    // MVN R7,R2
    start(16'hB8E2);
    @(negedge clk);
    ctl("mvn_get_b", 1'b0, 3'b010, 3'b000, 4'b0001, 7'b0100000, 2'b00, 2'b00);
    @(negedge clk);
    ctl("mvn_alu", 1'b0, 3'b000, 3'b000, 4'b0001, 7'b0010010, 2'b00, 2'b11);
    @(negedge clk);
    ctl("mvn_write_reg", 1'b0, 3'b000, 3'b111, 4'b0001, 7'b0000100, 2'b00, 2'b00);
    @(negedge clk);
    idle("mvn_done");

    // Illegal opcode 111 and illegal 110/01
    start(16'hE000);
    busy_quiet("illegal_e000_decode");
    @(negedge clk);
    idle("illegal_e000_done");
    start(16'hC800);
    busy_quiet("illegal_c800_decode");
    @(negedge clk);
    idle("illegal_c800_done");

    // Reset during GET_B of an ADD
    start(16'hA2A3);
    @(negedge clk);
    @(negedge clk);
    ctl("rst_add_get_b", 1'b0, 3'b011, 3'b000, 4'b0001, 7'b0100000, 2'b00, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle("rst_midflight_wait");
    chk16("rst_midflight_ir", sximm8, 16'h0000);
    @(negedge clk);
    idle("rst_midflight_no_write");

    // s held high while busy: a new word presented mid-instruction is only taken back in WAIT
    in = 16'hD107;
    s  = 1'b1;
    @(negedge clk);
    in = 16'hA2A3;
    busy_quiet("hold_s_decode");
    @(negedge clk);
    ctl("hold_s_write_imm", 1'b0, 3'b000, 3'b001, 4'b0100, 7'b0000100, 2'b00, 2'b00);
    @(negedge clk);
    idle("hold_s_wait");
    @(negedge clk);
    s = 1'b0;
    busy_quiet("hold_s_restart_decode");
    @(negedge clk);
    ctl("hold_s_second_get_a", 1'b0, 3'b010, 3'b000, 4'b0001, 7'b1000000, 2'b00, 2'b00);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ctl("hold_s_second_write", 1'b0, 3'b000, 3'b101, 4'b0001, 7'b0000100, 2'b00, 2'b00);
    @(negedge clk);
    idle("hold_s_second_done");

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
